// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 1-D convolution sequencer.
//   - conv_state_t : sequencer state encoding, also exported on the debug port
//   - CR_*         : field offsets/widths inside the configuration word
//   - MAC_LAT_DEF  : default MAC datapath latency (mac_en cycle -> accumulator)
//   - size_ok()    : legality check of one sequence length
package conv_pkg;

    typedef enum logic [2:0] {
        ST_STANDBY  = 3'd0,
        ST_CONFIG   = 3'd1,
        ST_OUT_INIT = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } conv_state_t;

    localparam int CR_SIZE_X_LSB = 0;
    localparam int CR_SIZE_H_LSB = 8;
    localparam int CR_SIZE_W     = 8;

    localparam int MAC_LAT_DEF = 2;

    // A length is legal when it is non-zero and fits the input memory.
    function automatic logic size_ok(input logic [CR_SIZE_W-1:0] sz, input int aw);
        return (sz != '0) && (int'(sz) <= (1 << aw));
    endfunction

endpackage

// File: rtl/conv_idx_gen.sv
// conv_idx_gen: k-range generator for one output index n.
//   Inputs : clk, rst_a (async, active low), en_s (clock enable), load,
//            n, size_x, size_h (signed, NW bits)
//   Outputs: k_lo   - first k for this n, combinational from n
//            j_lo   - n - k_lo, the matching first H address, combinational
//            k_hi   - last k for this n, registered on load
//            last_n - n is the final output index, registered on load
// k_lo/j_lo are consumed in the same cycle that load is high; k_hi/last_n
// are consumed in the following ISSUE/DRAIN cycles.
module conv_idx_gen
    import conv_pkg::*;
#(
    parameter int NW = 8
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic                 load,
    input  logic signed [NW-1:0] n,
    input  logic signed [NW-1:0] size_x,
    input  logic signed [NW-1:0] size_h,
    output logic signed [NW-1:0] k_lo,
    output logic signed [NW-1:0] j_lo,
    output logic signed [NW-1:0] k_hi,
    output logic                 last_n
);

    localparam logic signed [NW-1:0] ONE = NW'(1);

    logic signed [NW-1:0] lo_raw;
    logic signed [NW-1:0] hi_raw;
    logic signed [NW-1:0] k_hi_c;
    logic                 last_c;

    always_comb begin
        // n-size_h+1 goes negative for the leading outputs; clamp at 0.
        lo_raw = n - size_h + ONE;
        k_lo   = lo_raw[NW-1] ? '0 : lo_raw;
        j_lo   = n - k_lo;
        hi_raw = size_x - ONE;
        k_hi_c = (n < hi_raw) ? n : hi_raw;
        last_c = (n == (size_x + size_h - ONE - ONE));
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            k_hi   <= '0;
            last_n <= 1'b0;
        end else if (en_s && load) begin
            k_hi   <= k_hi_c;
            last_n <= last_c;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer of the 1-D convolution coprocessor,
// y[n] = sum_k x[k]*h[n-k].
//   clk, rst_a      : clock, asynchronous active-low reset
//   en_s            : global clock enable, low freezes every register
//   start, confReg  : run request and {size_h, size_x} configuration
//   addrX, addrH    : X/H memory read addresses (k and n-k)
//   mac_en, mac_clr : MAC accumulate strobe / load-first-product qualifier
//   addrWR, enWR    : output memory write address (n) and enable
//   busy_f, done_f  : run in progress / one-cycle completion pulse
//   cfg_err         : last start carried an illegal size, sticky
//   dbg_state       : current sequencer state
//
// Control protocol: start is a level request sampled only in STANDBY; the
// cycle after acceptance busy_f is high and stays high until the sequencer
// is back in STANDBY. done_f pulses for exactly one cycle at the end of
// every accepted start, including one rejected for illegal sizes. There is
// no backpressure from the memories or the MAC.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH_MEMI = 6,
    parameter int ADDR_WIDTH_MEMO = 7,
    parameter int SIZE_CR         = 1,
    parameter int MAC_LAT         = MAC_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_a,
    input  logic                       en_s,
    input  logic                       start,
    input  logic [SIZE_CR*32-1:0]      confReg,
    output logic [ADDR_WIDTH_MEMI-1:0] addrX,
    output logic [ADDR_WIDTH_MEMI-1:0] addrH,
    output logic                       mac_en,
    output logic                       mac_clr,
    output logic [ADDR_WIDTH_MEMO-1:0] addrWR,
    output logic                       enWR,
    output logic                       busy_f,
    output logic                       done_f,
    output logic                       cfg_err,
    output conv_state_t                dbg_state
);

    // One extra bit over the output address keeps n-size_h+1 signed.
    localparam int NW = ADDR_WIDTH_MEMO + 1;
    localparam int DW = $clog2(MAC_LAT + 2);
    localparam logic signed [NW-1:0] ONE = NW'(1);

    conv_state_t          state;
    logic signed [NW-1:0] n_r;
    logic signed [NW-1:0] k_r;
    logic signed [NW-1:0] j_r;
    logic signed [NW-1:0] sx_r;
    logic signed [NW-1:0] sh_r;
    logic                 first_r;
    logic [DW-1:0]        drain_r;

    logic signed [NW-1:0] k_lo;
    logic signed [NW-1:0] j_lo;
    logic signed [NW-1:0] k_hi;
    logic                 last_n;

    logic [CR_SIZE_W-1:0] cfg_sx;
    logic [CR_SIZE_W-1:0] cfg_sh;
    logic                 cfg_ok;
    logic                 cfg_unused;

    assign cfg_sx     = confReg[CR_SIZE_X_LSB +: CR_SIZE_W];
    assign cfg_sh     = confReg[CR_SIZE_H_LSB +: CR_SIZE_W];
    assign cfg_ok     = size_ok(cfg_sx, ADDR_WIDTH_MEMI) && size_ok(cfg_sh, ADDR_WIDTH_MEMI);
    assign cfg_unused = ^confReg[SIZE_CR*32-1:16];

    // Read addresses come straight from the k and n-k counters.
    assign addrX     = k_r[ADDR_WIDTH_MEMI-1:0];
    assign addrH     = j_r[ADDR_WIDTH_MEMI-1:0];
    assign dbg_state = state;

    conv_idx_gen #(
        .NW (NW)
    ) u_idx (
        .clk    (clk),
        .rst_a  (rst_a),
        .en_s   (en_s),
        .load   (state == ST_OUT_INIT),
        .n      (n_r),
        .size_x (sx_r),
        .size_h (sh_r),
        .k_lo   (k_lo),
        .j_lo   (j_lo),
        .k_hi   (k_hi),
        .last_n (last_n)
    );

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state   <= ST_STANDBY;
            n_r     <= '0;
            k_r     <= '0;
            j_r     <= '0;
            sx_r    <= '0;
            sh_r    <= '0;
            first_r <= 1'b0;
            drain_r <= '0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            addrWR  <= '0;
            enWR    <= 1'b0;
            busy_f  <= 1'b0;
            done_f  <= 1'b0;
            cfg_err <= 1'b0;
        end else if (en_s) begin
            // mac_en/mac_clr are the one-stage delay of the issue slot, so
            // they line up with the synchronous memory read data.
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            enWR    <= 1'b0;
            case (state)
                ST_STANDBY: begin
                    done_f <= 1'b0;
                    if (start) begin
                        state   <= ST_CONFIG;
                        busy_f  <= 1'b1;
                        cfg_err <= 1'b0;
                    end
                end
                ST_CONFIG: begin
                    sx_r <= NW'(cfg_sx);
                    sh_r <= NW'(cfg_sh);
                    if (!cfg_ok) begin
                        state   <= ST_STANDBY;
                        cfg_err <= 1'b1;
                        busy_f  <= 1'b0;
                        done_f  <= 1'b1;
                    end else begin
                        n_r   <= '0;
                        state <= ST_OUT_INIT;
                    end
                end
                ST_OUT_INIT: begin
                    k_r     <= k_lo;
                    j_r     <= j_lo;
                    first_r <= 1'b1;
                    state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    mac_en  <= 1'b1;
                    mac_clr <= first_r;
                    first_r <= 1'b0;
                    if (k_r == k_hi) begin
                        state   <= ST_DRAIN;
                        drain_r <= DW'(MAC_LAT + 1);
                    end else begin
                        k_r <= k_r + ONE;
                        j_r <= j_r - ONE;
                    end
                end
                ST_DRAIN: begin
                    drain_r <= drain_r - DW'(1);
                    // enWR is registered: raise it one count early so it is
                    // visible in the final drain cycle, MAC_LAT+1 after the
                    // last issue.
                    if (drain_r == DW'(2)) begin
                        enWR   <= 1'b1;
                        addrWR <= n_r[ADDR_WIDTH_MEMO-1:0];
                    end
                    if (drain_r == DW'(1)) begin
                        if (last_n) begin
                            state  <= ST_DONE;
                            done_f <= 1'b1;
                        end else begin
                            n_r   <= n_r + ONE;
                            state <= ST_OUT_INIT;
                        end
                    end
                end
                ST_DONE: begin
                    done_f <= 1'b0;
                    busy_f <= 1'b0;
                    state  <= ST_STANDBY;
                end
                default: state <= ST_STANDBY;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: bench for conv_seq_ctrl with behavioural X/H memories,
// a MAC model and an expected-write queue.
module tb_conv_seq_ctrl;
    import conv_pkg::*;

    localparam int AWI = 6;
    localparam int AWO = 7;
    localparam int ML  = MAC_LAT_DEF;   // model below needs ML >= 2
    localparam int SW  = AWO + 32;
    localparam int OW  = 2 * AWI + AWO + 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a;
    logic           en_s;
    logic           start;
    logic [31:0]    confReg;
    logic [AWI-1:0] addrX, addrH;
    logic           mac_en, mac_clr;
    logic [AWO-1:0] addrWR;
    logic           enWR, busy_f, done_f, cfg_err;
    conv_state_t    dbg_state;

    conv_seq_ctrl #(
        .ADDR_WIDTH_MEMI (AWI),
        .ADDR_WIDTH_MEMO (AWO),
        .SIZE_CR         (1),
        .MAC_LAT         (ML)
    ) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .en_s      (en_s),
        .start     (start),
        .confReg   (confReg),
        .addrX     (addrX),
        .addrH     (addrH),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .addrWR    (addrWR),
        .enWR      (enWR),
        .busy_f    (busy_f),
        .done_f    (done_f),
        .cfg_err   (cfg_err),
        .dbg_state (dbg_state)
    );

    // ---------------- memory + MAC models ----------------
    logic [7:0]  xmem [64];
    logic [7:0]  hmem [64];
    logic [7:0]  xd, hd;
    logic        pv [ML-1];
    logic        pc [ML-1];
    logic [31:0] pp [ML-1];
    logic [31:0] acc;

    initial begin
        for (int i = 0; i < ML - 1; i++) begin
            pv[i] = 1'b0;
            pc[i] = 1'b0;
            pp[i] = '0;
        end
        acc = '0;
    end

    // Product of a mac_en cycle reaches acc ML cycles later.
    always @(posedge clk) begin
        if (en_s) begin
            xd    <= xmem[addrX];
            hd    <= hmem[addrH];
            pv[0] <= mac_en;
            pc[0] <= mac_clr;
            pp[0] <= 32'(xd) * 32'(hd);
            for (int i = 1; i < ML - 1; i++) begin
                pv[i] <= pv[i-1];
                pc[i] <= pc[i-1];
                pp[i] <= pp[i-1];
            end
            if (pv[ML-2]) acc <= pc[ML-2] ? pp[ML-2] : acc + pp[ML-2];
        end
    end

    // ---------------- scoreboard ----------------
    logic [SW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [OW-1:0] outs();
        return {addrX, addrH, mac_en, mac_clr, addrWR, enWR, busy_f, done_f, cfg_err, dbg_state};
    endfunction

    task automatic sb_write();
        logic [SW-1:0] e;
        chk("sb_write_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", longint'(addrWR), longint'(e[SW-1:32]));
            chk("wr_data", longint'(acc), longint'(e[31:0]));
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic fill_mem(input int pat);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                0:       begin xmem[i] = 8'(i + 1); hmem[i] = 8'(i + 4); end
                1:       begin xmem[i] = 8'd1; hmem[i] = 8'd1; end
                2:       begin xmem[i] = 8'($urandom_range(0, 255)); hmem[i] = 8'($urandom_range(0, 255)); end
                default: begin xmem[i] = 8'd7; hmem[i] = 8'd6; end
            endcase
        end
    endtask

    function automatic logic [31:0] ref_y(input int n, input int sx, input int sh);
        logic [31:0] s = '0;
        for (int k = 0; k < sx; k++)
            if (n - k >= 0 && n - k < sh) s += 32'(xmem[k]) * 32'(hmem[n-k]);
        return s;
    endfunction

    typedef struct {
        int sx, sh, pat, stall, midstart;
        int exp_wr, exp_mac, exp_clr, exp_cyc, exp_err, exp_max;
    } vec_t;

    task automatic run_case(input vec_t v);
        int cyc = 0, first_oi = 0, last_wr = 0, done_cyc = 0;
        int n_wr = 0, n_mac = 0, n_clr = 0, max_addr = 0;
        int stall_left = 0, stall_phase = 0;
        bit seen_oi = 0, seen_done = 0;
        logic err_at_done = 1'b0;
        logic [OW-1:0] snap = '0;
        fill_mem(v.pat);
        if (v.exp_err == 0)
            for (int n = 0; n < v.sx + v.sh - 1; n++)
                exp_q.push_back({AWO'(n), ref_y(n, v.sx, v.sh)});
        confReg = {16'h0, 8'(v.sh), 8'(v.sx)};
        en_s  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", longint'(busy_f), 1);
        chk("start_clears_cfg_err", longint'(cfg_err), 0);
        for (int c = 0; c < 8000 && !seen_done; c++) begin
            @(negedge clk);
            start = (v.midstart != 0 && cyc == 9);
            en_s  = 1'b1;
            if (stall_left > 0) begin
                en_s = 1'b0;
                stall_left--;
                if (stall_left == 0) chk("stall_hold", longint'(outs()), longint'(snap));
            end else if (v.stall != 0 &&
                         ((stall_phase == 0 && dbg_state == ST_ISSUE && n_wr == 1) ||
                          (stall_phase == 1 && dbg_state == ST_DRAIN && enWR))) begin
                snap        = outs();
                en_s        = 1'b0;
                stall_left  = 4;
                stall_phase++;
            end
            if (en_s) begin
                cyc++;
                if (!seen_oi && dbg_state == ST_OUT_INIT) begin
                    seen_oi  = 1;
                    first_oi = cyc;
                end
                n_mac += int'(mac_en);
                n_clr += int'(mac_clr);
                if (enWR) begin
                    n_wr++;
                    last_wr = cyc;
                    if (int'(addrWR) > max_addr) max_addr = int'(addrWR);
                    sb_write();
                end
                if (done_f) begin
                    seen_done   = 1;
                    done_cyc    = cyc;
                    err_at_done = cfg_err;
                end
            end
        end
        en_s  = 1'b1;
        start = 1'b0;
        chk("done_seen", longint'(seen_done), 1);
        chk("cfg_err_at_done", longint'(err_at_done), v.exp_err);
        chk("write_count", n_wr, v.exp_wr);
        chk("mac_en_count", n_mac, v.exp_mac);
        chk("mac_clr_count", n_clr, v.exp_clr);
        if (v.stall != 0) chk("stall_count", stall_phase, 2);
        if (v.exp_err == 0) begin
            chk("cycles_oi_to_last_wr", last_wr - first_oi + 1, v.exp_cyc);
            chk("done_after_last_wr", done_cyc, last_wr + 1);
            chk("max_addrWR", max_addr, v.exp_max);
        end
        chk("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        chk("post_busy_low", longint'(busy_f), 0);
        chk("post_done_low", longint'(done_f), 0);
        chk("post_cfg_err", longint'(cfg_err), v.exp_err);
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl [8];
    vec_t mid_v;

    initial begin
        int n_wr, n_act, ndone, d1;
        bit hit;

        // sx sh pat stall mid | wr mac clr cyc err max
        tbl[0] = '{3,  2,  0, 0, 0,   4,    6,   4,   22, 0,   3};
        tbl[1] = '{1,  1,  3, 0, 0,   1,    1,   1,    5, 0,   0};
        tbl[2] = '{0,  4,  0, 0, 0,   0,    0,   0,    0, 1,   0};
        tbl[3] = '{3,  65, 0, 0, 0,   0,    0,   0,    0, 1,   0};
        tbl[4] = '{64, 64, 1, 0, 0, 127, 4096, 127, 4604, 0, 126};
        tbl[5] = '{3,  2,  0, 1, 0,   4,    6,   4,   22, 0,   3};
        tbl[6] = '{5,  3,  2, 0, 0,   7,   15,   7,   43, 0,   6};
        tbl[7] = '{2,  4,  2, 0, 0,   5,    8,   5,   28, 0,   4};
        mid_v  = '{3,  2,  0, 0, 1,   4,    6,   4,   22, 0,   3};

        rst_a   = 1'b0;
        en_s    = 1'b1;
        start   = 1'b0;
        confReg = '0;
        fill_mem(0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", longint'(outs()), 0);
        rst_a = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", longint'(outs()), 0);

        for (int i = 0; i < 8; i++) run_case(tbl[i]);

        // Reset in the DRAIN of n=2 aborts at once.
        fill_mem(0);
        confReg = {16'h0, 8'd2, 8'd3};
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_wr  = 0;
        hit   = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (enWR) n_wr++;
            if (dbg_state == ST_DRAIN && !enWR && n_wr == 2) hit = 1;
        end
        chk("reached_drain_n2", longint'(hit), 1);
        #2 rst_a = 1'b0;
        #1 chk("reset_abort_outputs", longint'(outs()), 0);
        @(negedge clk);
        rst_a = 1'b1;
        n_act = 0;
        repeat (6) begin
            @(negedge clk);
            n_act += int'(enWR) + int'(mac_en) + int'(busy_f);
        end
        chk("quiet_after_abort", n_act, 0);

        // Clean run after the abort, with a start pulse while busy.
        run_case(mid_v);

        // start held high across DONE restarts from the next STANDBY cycle.
        fill_mem(3);
        confReg = {16'h0, 8'd1, 8'd1};
        exp_q.push_back({AWO'(0), 32'd42});
        exp_q.push_back({AWO'(0), 32'd42});
        start = 1'b1;
        ndone = 0;
        d1    = -1;
        n_wr  = 0;
        for (int c = 0; c < 100 && ndone < 2; c++) begin
            @(negedge clk);
            if (enWR) begin
                n_wr++;
                sb_write();
            end
            if (d1 >= 0 && c == d1 + 1) begin
                chk("held_standby_busy", longint'(busy_f), 0);
                chk("held_standby_done", longint'(done_f), 0);
            end
            if (d1 >= 0 && c == d1 + 2) begin
                chk("held_restart_busy", longint'(busy_f), 1);
                start = 1'b0;
            end
            if (done_f) begin
                ndone++;
                if (ndone == 1) d1 = c;
            end
        end
        start = 1'b0;
        chk("held_two_runs", ndone, 2);
        chk("held_writes", n_wr, 2);
        chk("held_sb_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("held_final_idle", longint'(busy_f), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the 1-D convolution coprocessor, y[n] = sum_k x[k]*h[n-k].
- Walks the output index n and, for each n, the valid k range.
- Drives read addresses into the X and H input memories (synchronous, 1-cycle read) and the enable/clear controls of an external MAC datapath.
- Writes each finished accumulator to the output memory.
- Sits between the picorv32-side register/flag interface (start, confReg, busy/done) and the MAC + memories.

Parameters:
ADDR_WIDTH_MEMI, 6, address width of the X and H memories; max length of each sequence = 2^ADDR_WIDTH_MEMI.
ADDR_WIDTH_MEMO, 7, output memory address width; must be >= ADDR_WIDTH_MEMI+1.
SIZE_CR, 1, number of 32-bit configuration words.
MAC_LAT, 2, cycles from a mac_en cycle to the accumulator holding that product; range 1..7.

Ports:
clk  in  1  clock
rst_a  in  1  asynchronous active-low reset
en_s  in  1  global clock enable; low freezes all state and outputs
start  in  1  start request, sampled in STANDBY only
confReg  in  SIZE_CR*32  [7:0] size_x, [15:8] size_h, [31:16] ignored
addrX  out  ADDR_WIDTH_MEMI  X memory read address (k)
addrH  out  ADDR_WIDTH_MEMI  H memory read address (n-k)
mac_en  out  1  MAC accumulate strobe, aligned with memory read data
mac_clr  out  1  with mac_en: load the product instead of adding it (first term of each n)
addrWR  out  ADDR_WIDTH_MEMO  output memory write address (n)
enWR  out  1  output memory write enable; accumulator is valid in this cycle
busy_f  out  1  operation in progress
done_f  out  1  one-cycle completion pulse
cfg_err  out  1  sticky until next start: last start had illegal sizes

Behaviour:
- Reset: all outputs 0, state STANDBY, internal counters 0. Asserting reset mid-operation aborts immediately; no further writes occur.
- en_s=0: no register changes, including the mac pipeline delay line. Outputs hold their values.
- STANDBY:
  - done_f, mac_en and enWR are 0.
  - start=1 -> CONFIG, busy_f<=1, cfg_err<=0.
  - start is ignored in every other state.
- CONFIG:
  - Latch size_x and size_h; Ny = size_x+size_h-1.
  - If either size is 0 or exceeds 2^ADDR_WIDTH_MEMI -> STANDBY, cfg_err<=1, busy_f<=0, done_f<=1. No writes occur.
  - Otherwise n<=0 -> OUT_INIT.
- OUT_INIT (1 cycle):
  - k_lo = max(0, n-size_h+1); k_hi = min(n, size_x-1).
  - k<=k_lo, first<=1 -> ISSUE.
- ISSUE (k_hi-k_lo+1 cycles):
  - Each cycle drive addrX=k, addrH=n-k, and push a valid bit (tagged with the current value of first) into a 1-stage delay.
  - The delayed bit produces mac_en exactly 1 cycle later; mac_clr=mac_en & first_delayed.
  - first<=0 after the first issue.
  - On k==k_hi -> DRAIN with drain counter = MAC_LAT+1.
- DRAIN:
  - Count down. enWR=1 with addrWR=n in exactly the cycle that is MAC_LAT+1 cycles after the last ISSUE cycle; enWR is 0 on every other cycle.
  - In that cycle: if n==Ny-1 -> DONE, else n<=n+1 -> OUT_INIT.
- DONE (1 cycle): done_f=1, busy_f<=0 -> STANDBY. done_f drops the following cycle.
- Cycle budget:
  - Per n: 1 + (k_hi-k_lo+1) + (MAC_LAT+1) cycles.
  - No overlap between outputs; next n's OUT_INIT starts the cycle after enWR.
- Width rules:
  - n and k arithmetic are done at ADDR_WIDTH_MEMO+1 bits, signed where n-size_h+1 can be negative. There is no wrap.
  - addrH is the low ADDR_WIDTH_MEMI bits of n-k, always in range by construction.
- Boundaries:
  - size_x=size_h=1 -> exactly one write to addr 0.
  - Max sizes (64,64) -> 127 writes, addrWR reaches 126.
  - If start is held high across DONE, a new run begins on the STANDBY cycle after the done_f pulse.

Decomposition:
- Shared package conv_pkg holds:
  - state encodings (STANDBY, CONFIG, OUT_INIT, ISSUE, DRAIN, DONE);
  - confReg field offsets/widths;
  - the MAC_LAT default.
- One sub-module, conv_idx_gen: combinational plus registered computation of k_lo, k_hi and the last-n flag from n, size_x and size_h. This isolates the signed/clamp arithmetic for unit testing.

Test Plan:
- x={1,2,3}, h={4,5}, MAC_LAT=2, behavioural MAC and RAM models:
  - 4 writes y={4,13,22,15} to addr 0..3;
  - mac_en count 6; mac_clr exactly 4 times;
  - 22 cycles from first OUT_INIT to last enWR; done_f next cycle; busy_f then low.
- size_x=1, size_h=1, x={7}, h={6}: one write of 42 to addr 0, then done_f.
- size_x=0 (and separately size_h=65): no mac_en and no enWR; done_f pulse; cfg_err=1 until the next start.
- size_x=size_h=64, all ones: 127 writes; y[63]=64, y[0]=y[126]=1; addrWR max 126.
- en_s low for 5 cycles in the middle of ISSUE and again in DRAIN: results identical to the run without stalls; enWR count unchanged.
- rst_a low during DRAIN of n=2: all outputs 0 immediately; a new start then completes a clean full run; start pulsed while busy is ignored.
